dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder (slave) end of the CPU data-memory interface: accepts dmem_read/dmem_write requests from cpu_top and returns read data.
- Adds configurable wait states through a stall handshake, so the core can be exercised against slow memory before the cache/AXI path is attached.
- Holds a word-addressed storage array.
- Flags out-of-range and misaligned accesses.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two.
- LATENCY, 2, stall cycles per access; 0 means single-cycle, combinational response.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on an erroring read.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- dmem_read  input  1  read request; held stable by the CPU while dmem_stall is high.
- dmem_write  input  1  write request; held stable while dmem_stall is high.
- dmem_addr  input  32  byte address; word index is dmem_addr[log2(DEPTH)+1:2].
- dmem_wdata  input  32  write data.
- dmem_rdata  output  32  read data; valid only in the response cycle, otherwise 0.
- dmem_stall  output  1  high while the CPU must hold its request and freeze.
- dmem_err  output  1  one-cycle pulse in the response cycle of a faulting access.

Behaviour:
- One clock. Reset is asynchronous and active-low, ports clk and reset_n.
- Reset values: state IDLE, dmem_stall 0, dmem_rdata 0, dmem_err 0, wait counter 0, request latches 0. Array contents are not reset.
- Request: req = dmem_read | dmem_write.
- Both dmem_read and dmem_write high is a protocol error: treated as a faulting access, no array access, dmem_err pulses.
- Fault conditions: dmem_addr[1:0] != 0, or dmem_addr >= DEPTH*4. A faulting write is dropped; a faulting read returns ERR_RDATA.
- LATENCY == 0 (no FSM traversal):
  - A read drives dmem_rdata = mem[idx] combinationally in the same cycle.
  - A write commits at the same rising edge.
  - dmem_stall stays 0.
  - dmem_err is combinational for that cycle.
- LATENCY > 0, FSM states IDLE, WAIT, RESP:
  - IDLE: if req, dmem_stall goes high combinationally in the same cycle. Latch op, idx, wdata and fault at the edge. Load counter with LATENCY-1. Next state is WAIT if LATENCY > 1, else RESP.
  - WAIT: dmem_stall = 1; counter decrements each cycle; when counter == 0, next state is RESP.
  - RESP: dmem_stall = 0.
    - Read: dmem_rdata = registered data from the latched index, or ERR_RDATA on fault.
    - Write: commits at the end of RESP, unless faulting.
    - dmem_err = latched fault.
    - Next state is IDLE unconditionally; back-to-back requests take effect the cycle after RESP.
  - Total stall = exactly LATENCY cycles per access. Throughput is one access per LATENCY+1 cycles.
- Requests arriving in WAIT or RESP are ignored; the latched request is authoritative.
- Input changes during a stall do not affect the transaction in flight.
- Reset asserted mid-transaction:
  - Immediately returns to IDLE and drops stall and err.
  - A pending write is discarded; array contents written earlier are preserved.
- Counter width is clog2(LATENCY+1); it never wraps. Index arithmetic truncates to log2(DEPTH) bits only after the range check.
- dmem_rdata is 0 in every non-response cycle, including the first stall cycle.

Decomposition:
- Package dmem_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t
  - DATA_W = 32
  - typedef struct for the latched request: is_read, is_write, idx, wdata, fault.
- Sub-module dmem_sram_array: DEPTH x 32 array with a synchronous write port, plus an asynchronous read port for LATENCY == 0 and a registered read port.
- FSM, range/alignment checking and counter live in dmem_responder.

Test Plan:
- LATENCY=0: write 0x0000_00AB to addr 0x10, then read 0x10 → dmem_rdata = 0xAB in the read cycle, dmem_stall never high.
- LATENCY=2:
  - Read addr 0x20 preloaded with 0x1234_5678 → dmem_stall high for exactly 2 cycles, then one cycle with dmem_rdata = 0x1234_5678, stall = 0.
  - Read addr 0x22 (misaligned) → stall 2 cycles, then response cycle with dmem_err = 1, dmem_rdata = 0xDEAD_BEEF.
  - Write addr 0x400 (out of range, DEPTH=256) → dmem_err = 1 in the response cycle, no array word changes.
- LATENCY=3: write 0x55 to addr 0x8; during the first WAIT cycle change dmem_addr to 0xC and dmem_wdata to 0x99 → mem[2] = 0x55, mem[3] unchanged.
- LATENCY=2: assert reset_n = 0 during WAIT of a write to 0x30 (old value 0x7) → stall drops asynchronously, state IDLE, mem[12] still 0x7.
- LATENCY=1: dmem_read and dmem_write both high at 0x4 → err pulse, no write, rdata = 0xDEAD_BEEF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// Request latch layout and FSM state encoding.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = DATA_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic              is_read;
        logic              is_write;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] wdata;
        logic              fault;
    } dmem_req_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Word storage: one synchronous write port, one combinational read
// port and one registered read port. Contents are never reset.
module dmem_sram_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     aaddr,
    output logic [DATA_W-1:0] adata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

    assign adata = mem[aaddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with configurable wait states.
// Faulting accesses (misaligned, out of range, read+write) pulse dmem_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                DEPTH     = 256,
    parameter int                LATENCY   = 2,
    parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [DATA_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_stall,
    output logic              dmem_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(DEPTH * 4);
    localparam dmem_state_t FIRST = (LATENCY > 1) ? WAIT : RESP;

    dmem_state_t       state_q;
    dmem_state_t       state_d;
    dmem_req_t         lat_q;
    dmem_req_t         lat_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              req;
    logic              fault;
    logic [AW-1:0]     idx;

    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] adata;
    logic              re;
    logic [DATA_W-1:0] rdata_q;
    logic              unused_idx;

    assign req   = dmem_read | dmem_write;
    assign idx   = dmem_addr[AW+1:2];
    // Range check uses the full address; truncation to AW happens after.
    assign fault = (dmem_addr[1:0] != 2'b00)
                 | (dmem_addr >= ADDR_LIMIT)
                 | (dmem_read & dmem_write);

    assign unused_idx = ^lat_q.idx[IDX_W-1:AW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        cnt_d      = cnt_q;
        dmem_stall = 1'b0;
        dmem_rdata = '0;
        dmem_err   = 1'b0;
        we         = 1'b0;
        waddr      = lat_q.idx[AW-1:0];
        wdata      = lat_q.wdata;
        if (LATENCY == 0) begin
            waddr    = idx;
            wdata    = dmem_wdata;
            we       = dmem_write & ~fault;
            dmem_err = req & fault;
            if (dmem_read) begin
                dmem_rdata = fault ? ERR_RDATA : adata;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        dmem_stall     = 1'b1;
                        lat_d.is_read  = dmem_read;
                        lat_d.is_write = dmem_write;
                        lat_d.idx      = IDX_W'(idx);
                        lat_d.wdata    = dmem_wdata;
                        lat_d.fault    = fault;
                        cnt_d          = CNT_LOAD;
                        state_d        = FIRST;
                    end
                end
                WAIT: begin
                    dmem_stall = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (lat_q.is_read) begin
                        dmem_rdata = lat_q.fault ? ERR_RDATA : rdata_q;
                    end
                    dmem_err = lat_q.fault;
                    we       = lat_q.is_write & ~lat_q.fault;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Registered read fires on the edge that enters RESP.
    assign re = (LATENCY > 0) && (state_d == RESP) && (state_q != RESP);

    dmem_sram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .aaddr (idx),
        .adata (adata),
        .re    (re),
        .raddr (lat_d.idx[AW-1:0]),
        .rdata (rdata_q)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: four responders (LATENCY 0..3) driven with
// directed and random traffic against a word-array reference model.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic void check(string name, int ln,
                                  logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s lane%0d got=%h exp=%h", name, ln, got, exp);
        end
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int L = g;

        logic        rst_n;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        stall;
        logic        err;
        logic [31:0] model [256];
        exp_t        exp_q [$];
        bit          fin = 1'b0;

        dmem_responder #(
            .DEPTH     (256),
            .LATENCY   (L),
            .ERR_RDATA (32'hDEAD_BEEF)
        ) dut (
            .clk        (clk),
            .reset_n    (rst_n),
            .dmem_read  (rd),
            .dmem_write (wr),
            .dmem_addr  (addr),
            .dmem_wdata (wdata),
            .dmem_rdata (rdata),
            .dmem_stall (stall),
            .dmem_err   (err)
        );

        function automatic bit is_fault(bit r, bit w, logic [31:0] a);
            return (a % 4 != 0) || (a >= 32'd1024) || (r && w);
        endfunction

        task automatic access(input bit r, input bit w,
                              input logic [31:0] a, input logic [31:0] d,
                              input bit perturb);
            exp_t e;
            bit   f;
            int   n;
            f = is_fault(r, w, a);
            e.rdata = r ? (f ? 32'hDEAD_BEEF : model[a / 4]) : 32'h0;
            e.err   = f;
            exp_q.push_back(e);
            if (w && !f) model[a / 4] = d;
            @(posedge clk);
            #1;
            rd = r;
            wr = w;
            addr = a;
            wdata = d;
            if (L > 0) begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (perturb && n == 1) begin
                        addr = 32'hC;
                        wdata = 32'h99;
                    end else if ($urandom_range(0, 3) == 0) begin
                        addr = $urandom;
                        wdata = $urandom;
                    end
                end while (stall && n < L + 4);
                check("stall_bound", L, {31'b0, stall}, 32'h0);
            end else begin
                @(posedge clk);
                #1;
            end
            rd = 1'b0;
            wr = 1'b0;
        endtask

        task automatic reset_write(input logic [31:0] a, input logic [31:0] d);
            exp_t e;
            if (L == 0) begin
                e.rdata = 32'h0;
                e.err   = 1'b0;
                exp_q.push_back(e);
                model[a / 4] = d;
            end
            @(posedge clk);
            #1;
            wr = 1'b1;
            addr = a;
            wdata = d;
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            wr = 1'b0;
            #1;
            check("rst_mid_stall", L, {31'b0, stall}, 32'h0);
            check("rst_mid_err", L, {31'b0, err}, 32'h0);
            check("rst_mid_rdata", L, rdata, 32'h0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        endtask

        if (L == 0) begin : mon
            always @(negedge clk) begin
                if (rst_n) begin
                    check("l0_stall", L, {31'b0, stall}, 32'h0);
                    if (rd || wr) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_resp", L, 32'h1, 32'h0);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("rdata", L, rdata, e.rdata);
                            check("err", L, {31'b0, err}, {31'b0, e.err});
                        end
                    end else begin
                        check("idle_rdata", L, rdata, 32'h0);
                    end
                end
            end
        end else begin : mon
            bit prev_stall = 1'b0;
            int run = 0;
            always @(negedge clk) begin
                if (!rst_n) begin
                    prev_stall = 1'b0;
                    run = 0;
                end else begin
                    if (stall) run++;
                    if (prev_stall && !stall) begin
                        check("stall_len", L, run, L);
                        run = 0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_resp", L, 32'h1, 32'h0);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("rdata", L, rdata, e.rdata);
                            check("err", L, {31'b0, err}, {31'b0, e.err});
                        end
                    end else begin
                        check("idle_rdata", L, rdata, 32'h0);
                        check("idle_err", L, {31'b0, err}, 32'h0);
                    end
                    prev_stall = stall;
                end
            end
        end

        initial begin
            logic [31:0] a;
            int          k;
            rst_n = 1'b0;
            rd = 1'b0;
            wr = 1'b0;
            addr = '0;
            wdata = '0;
            #12;
            check("rst_stall", L, {31'b0, stall}, 32'h0);
            check("rst_rdata", L, rdata, 32'h0);
            check("rst_err", L, {31'b0, err}, 32'h0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int i = 0; i < 16; i++) access(1'b0, 1'b1, i * 4, $urandom, 1'b0);
            access(1'b0, 1'b1, 32'h3FC, $urandom, 1'b0);

            access(1'b0, 1'b1, 32'h10, 32'hAB, 1'b0);
            access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
            access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
            access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
            access(1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
            access(1'b0, 1'b1, 32'h400, 32'h1111, 1'b0);
            access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            access(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
            access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
            access(1'b1, 1'b0, 32'h3FD, 32'h0, 1'b0);
            access(1'b0, 1'b1, 32'h8, 32'h55, 1'b1);
            access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
            access(1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
            access(1'b1, 1'b1, 32'h4, 32'h2222, 1'b0);
            access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
            access(1'b0, 1'b1, 32'h30, 32'h7, 1'b0);
            reset_write(32'h30, 32'hFFFF);
            access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

            for (int i = 0; i < 150; i++) begin
                k = $urandom_range(0, 15);
                case ($urandom_range(0, 9))
                    0: a = k * 4 + $urandom_range(1, 3);
                    1: a = 32'd1024 + $urandom_range(0, 255) * 4;
                    2: a = ($urandom | 32'h8000_0000) & ~32'h3;
                    3: a = 32'h3FC;
                    default: a = k * 4;
                endcase
                k = $urandom_range(0, 9);
                access(k == 0 || (k >= 1 && k <= 4), k == 0 || k >= 5,
                       a, $urandom, 1'b0);
            end
            repeat (4) @(posedge clk);
            check("queue_drained", L, exp_q.size(), 32'h0);
            fin = 1'b1;
        end
    end

    initial begin
        int  cyc;
        bit  all_done;
        cyc = 0;
        all_done = 1'b0;
        while (!all_done && cyc < 60000) begin
            @(posedge clk);
            cyc++;
            all_done = lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin;
        end
        check("all_done", 0, {31'b0, all_done}, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
